pingpong_capture: RTL and testbench

PINGPONG_CAPTURE -- requirements
Module: pingpong_capture

---
 rtl/pingpong_capture.sv | 158 +++++++++++++++
 tb/tb_pingpong_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_capture.sv
// pingpong_capture: double-buffered multi-channel ADC frame capture.
//
// The writer fills one bank with 2^AW sample sets while the reader owns the
// other bank. When a frame completes it is handed to the reader (frame_ready,
// frame_bank). If the reader still holds the previous frame, the writer parks
// in WAIT_SWAP and counts the samples it drops until rd_done frees the bank.
//
// Ports:
//   clk, n_reset          clock, async active-low reset
//   start                 one-cycle arm pulse (ignored while busy)
//   continuous            level, capture frames back-to-back
//   sample_valid          strobe, sample_data carries one sample per channel
//   sample_data [NCH*DW]  channel k at [k*DW +: DW]
//   rd_addr [AW]          reader address into the ready frame
//   rd_data [NCH*DW]      registered read of bank frame_bank at rd_addr
//   rd_done               reader releases the ready frame
//   frame_ready           a complete frame is owned by the reader
//   frame_bank            bank index of the ready frame
//   overrun_cnt [16]      dropped-sample count, saturating
//   busy                  writer not IDLE

// One channel of storage: two banks, single write port, registered read.
module pingpong_lane_mem #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:1][0:DEPTH-1];

  // Storage is deliberately not reset.
  always_ff @(posedge clk)
    if (we) mem[wbank][waddr] <= wdata;

  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) rdata <= '0;
    else          rdata <= mem[rbank][raddr];
endmodule

module pingpong_capture #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int AW  = 9
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              sample_valid,
  input  logic [NCH*DW-1:0] sample_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [NCH*DW-1:0] rd_data,
  input  logic              rd_done,
  output logic              frame_ready,
  output logic              frame_bank,
  output logic [15:0]       overrun_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} state_t;

  state_t        state;
  logic [AW-1:0] w_addr;
  logic          wbank;
  logic          we;
  logic          last;

  logic [NCH-1:0][DW-1:0] lane_wdata;
  logic [NCH-1:0][DW-1:0] lane_rdata;

  assign lane_wdata = sample_data;
  assign rd_data    = lane_rdata;
  assign we         = (state == FILL) && sample_valid;
  assign last       = &w_addr;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    pingpong_lane_mem #(.DW(DW), .AW(AW)) u_lane (
      .clk    (clk),
      .n_reset(n_reset),
      .we     (we),
      .wbank  (wbank),
      .waddr  (w_addr),
      .wdata  (lane_wdata[k]),
      .rbank  (frame_bank),
      .raddr  (rd_addr),
      .rdata  (lane_rdata[k])
    );
  end

  // wbank only ever toggles at a handover, where frame_bank takes the old
  // wbank; so while frame_ready=1 the writer is always on the other bank.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      w_addr      <= '0;
      wbank       <= 1'b0;
      frame_bank  <= 1'b0;
      frame_ready <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_done && frame_ready) frame_ready <= 1'b0;
          if (start || continuous) begin
            state  <= FILL;
            busy   <= 1'b1;
            w_addr <= '0;
          end
        end
        FILL: begin
          if (sample_valid && last) begin
            // rd_done in the completing cycle counts as release + handover.
            if (!frame_ready || rd_done) begin
              frame_ready <= 1'b1;
              frame_bank  <= wbank;
              wbank       <= ~wbank;
              w_addr      <= '0;
              state       <= continuous ? FILL : IDLE;
              busy        <= continuous;
            end else begin
              state <= WAIT_SWAP;
            end
          end else begin
            if (sample_valid) w_addr <= w_addr + 1'b1;
            if (rd_done && frame_ready) frame_ready <= 1'b0;
          end
        end
        WAIT_SWAP: begin
          // Frame is complete; nowhere to put new samples until handover.
          if (sample_valid && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
          if (rd_done) begin
            frame_ready <= 1'b1;
            frame_bank  <= wbank;
            wbank       <= ~wbank;
            w_addr      <= '0;
            state       <= continuous ? FILL : IDLE;
            busy        <= continuous;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pingpong_capture.sv
// Bench for pingpong_capture (NCH=2, DW=8, AW=3): a vector table, hand-written
// corner sequences and a random phase, all checked against a frame-level model.
module tb_pingpong_capture;
  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          sample_valid = 1'b0;
  logic [15:0]   sample_data = '0;
  logic [2:0]    rd_addr = '0;
  logic [15:0]   rd_data;
  logic          rd_done = 1'b0;
  logic          frame_ready;
  logic          frame_bank;
  logic [15:0]   overrun_cnt;
  logic          busy;

  int checks = 0;
  int failures = 0;

  pingpong_capture #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .continuous(continuous),
    .sample_valid(sample_valid), .sample_data(sample_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_done(rd_done), .frame_ready(frame_ready),
    .frame_bank(frame_bank), .overrun_cnt(overrun_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---- frame-level reference model ----
  // A frame is a queue of collected sample sets; a full queue is "pending"
  // until the reader side can take it.
  bit          m_ready, m_fbank, m_wb, m_active, m_pending;
  int          m_ovr;
  logic [15:0] m_cur[$];
  logic [15:0] m_bank[2][8];
  bit          m_known[2][8];
  logic [15:0] m_rd;
  bit          m_rd_known;

  function automatic void model_reset();
    m_ready = 0; m_fbank = 0; m_wb = 0; m_active = 0; m_pending = 0;
    m_ovr = 0; m_cur.delete(); m_rd_known = 0;
  endfunction

  function automatic void handover(bit co);
    m_ready = 1; m_fbank = m_wb; m_wb = !m_wb;
    m_cur.delete(); m_pending = 0; m_active = co;
  endfunction

  function automatic void model_step(bit st, bit co, bit v, logic [15:0] d,
                                     bit rdn, logic [2:0] ra);
    m_rd_known = m_known[m_fbank][ra];
    m_rd       = m_bank[m_fbank][ra];
    if (m_pending) begin
      if (v && m_ovr < 65535) m_ovr++;
      if (rdn) handover(co);
    end else if (m_active) begin
      if (v) begin
        m_bank[m_wb][m_cur.size()]  = d;
        m_known[m_wb][m_cur.size()] = 1;
        m_cur.push_back(d);
      end
      if (m_cur.size() == 8) begin
        if (!m_ready || rdn) handover(co);
        else m_pending = 1;
      end else if (rdn) m_ready = 0;
    end else begin
      if (rdn) m_ready = 0;
      if (st || co) begin m_active = 1; m_cur.delete(); end
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(bit st, bit co, bit v, logic [15:0] d, bit rdn, logic [2:0] ra);
    @(negedge clk);
    start = st; continuous = co; sample_valid = v; sample_data = d;
    rd_done = rdn; rd_addr = ra;
    model_step(st, co, v, d, rdn, ra);
    @(posedge clk); #1;
    chk("model_state", {12'd0, frame_ready, frame_bank, busy, 1'b0, overrun_cnt},
        {12'd0, m_ready, m_fbank, (m_active || m_pending), 1'b0, m_ovr[15:0]});
    if (m_rd_known) chk("model_rd_data", {16'd0, rd_data}, {16'd0, m_rd});
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0; start = 0; continuous = 0; sample_valid = 0; rd_done = 0;
    #1;
    chk("reset_outputs", {12'd0, frame_ready, frame_bank, busy, 1'b0, overrun_cnt}, 32'd0);
    chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  typedef struct {
    bit st, co, v; logic [15:0] d; bit rdn; logic [2:0] ra;
    bit e_rdy, e_bank, e_busy; bit chk_rd; logic [15:0] e_rd;
  } vec_t;

  function automatic vec_t mk(bit st, bit co, bit v, logic [15:0] d, bit rdn,
                              logic [2:0] ra, bit er, bit eb, bit ebs,
                              bit crd, logic [15:0] erd);
    vec_t r;
    r.st = st; r.co = co; r.v = v; r.d = d; r.rdn = rdn; r.ra = ra;
    r.e_rdy = er; r.e_bank = eb; r.e_busy = ebs; r.chk_rd = crd; r.e_rd = erd;
    return r;
  endfunction

  vec_t tbl[12];

  initial begin
    logic [7:0] b;
    // single frame via start, then read, release, and a stray release
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      b = 8'(i);
      tbl[1+i] = mk(1'b0, 1'b0, 1'b1, {8'h80 | b, b}, 1'b0, 3'd0,
                    (i == 7), 1'b0, (i != 7), 1'b0, 16'h0);
    end
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8505);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8505);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8505);

    model_reset();
    for (int bk = 0; bk < 2; bk++)
      for (int a = 0; a < 8; a++) m_known[bk][a] = 0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].st, tbl[i].co, tbl[i].v, tbl[i].d, tbl[i].rdn, tbl[i].ra);
      chk($sformatf("tbl%0d_ready", i), {31'd0, frame_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_bank", i),  {31'd0, frame_bank},  {31'd0, tbl[i].e_bank});
      chk($sformatf("tbl%0d_busy", i),  {31'd0, busy},        {31'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_ovr", i),   {16'd0, overrun_cnt}, 32'd0);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), {16'd0, rd_data}, {16'd0, tbl[i].e_rd});
    end

    // continuous, no release: WAIT_SWAP, overrun, then release swaps banks
    do_reset();
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 16'(i * 3 + 1), 1'b0, 3'd0);
    chk("wait_ready", {31'd0, frame_ready}, 32'd1);
    chk("wait_bank",  {31'd0, frame_bank},  32'd0);
    chk("wait_busy",  {31'd0, busy},        32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0, 3'd0);
    chk("overrun_3", {16'd0, overrun_cnt}, 32'd3);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd2);
    chk("swap_bank",  {31'd0, frame_bank},  32'd1);
    chk("swap_ready", {31'd0, frame_ready}, 32'd1);
    chk("swap_idle",  {31'd0, busy},        32'd0);

    // release in the same cycle as the completing sample
    do_reset();
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 16'(i + 16'h100), 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd7);
    chk("same_ready", {31'd0, frame_ready}, 32'd1);
    chk("same_bank",  {31'd0, frame_bank},  32'd1);
    chk("same_ovr",   {16'd0, overrun_cnt}, 32'd0);

    // reset mid-frame abandons it; new start fills bank 0 from address 0
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 16'hAA00 + 16'(i), 1'b0, 3'd0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 16'h5500 + 16'(i), 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    chk("rst_refill_bank", {31'd0, frame_bank}, 32'd0);
    chk("rst_refill_addr0", {16'd0, rd_data}, 32'h5500);

    // stray rd_done, and start while busy must not restart the frame
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    chk("stray_done_ready", {31'd0, frame_ready}, 32'd0);
    chk("stray_done_bank",  {31'd0, frame_bank},  32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h6600 + 16'(i), 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b1, 16'h6603, 1'b0, 3'd0);
    for (int i = 4; i < 8; i++) step(1'b0, 1'b0, 1'b1, 16'h6600 + 16'(i), 1'b0, 3'd0);
    chk("busy_start_ready", {31'd0, frame_ready}, 32'd1);
    chk("busy_start_bank",  {31'd0, frame_bank},  32'd1);

    // saturation of the drop counter
    do_reset();
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 16'(i), 1'b0, 3'd0);
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 3'd0);
    chk("ovr_saturate", {16'd0, overrun_cnt}, 32'h0000FFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd0);

    // random traffic against the model
    begin
      bit co;
      co = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(63) == 0) co = !co;
        step(($urandom_range(15) == 0), co, ($urandom_range(1) == 1),
             16'($urandom), ($urandom_range(7) == 0), 3'($urandom_range(7)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
